// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: walks operands LSB first through one external 1-bit ALU slice.
// Latency: done WIDTH+1 edges after the accepting edge (2*WIDTH+1 for SLT, 1 for an unsupported opcode).
// Backpressure: start is only accepted in IDLE; requests while busy or done are dropped.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             err,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_less,
    output logic             alu_cin,
    output logic             alu_ainv,
    output logic             alu_binv,
    output logic             alu_opA,
    output logic             alu_opB,
    input  logic             alu_result,
    input  logic             alu_cout
);

    localparam int             IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

    // opcode encoding is {ainv, binv, opA, opB}
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [3:0]        r_op;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_set;
    logic [WIDTH-1:0]  r_result;
    logic              r_ovf;
    logic              r_err;
    logic              r_busy;
    logic              r_done;

    logic              w_supported;
    logic              w_active;
    logic [3:0]        w_op_eff;
    logic              w_cin;

    // Decode which incoming opcodes the sequencer knows how to run
    always_comb begin
        w_supported = 1'b0;
        case (opcode)
            OP_AND, OP_OR, OP_XOR, OP_ADD,
            OP_SUB, OP_SLT, OP_NOR: w_supported = 1'b1;
            default:                w_supported = 1'b0;
        endcase
    end

    // PASS1 is always a subtract so the sign of a-b can be found before the SLT pass
    assign w_active = (r_state == PASS1) || (r_state == PASS2);
    assign w_op_eff = (r_state == PASS1) ? OP_SUB : r_op;
    assign w_cin    = (r_idx == '0) ? w_op_eff[2] : r_carry;

    // Slice drive: all zero outside the two passes so the slice sees a quiet AND of zeros
    assign alu_a    = w_active & r_a[r_idx];
    assign alu_b    = w_active & r_b[r_idx];
    assign alu_cin  = w_active & w_cin;
    assign alu_ainv = w_active & w_op_eff[3];
    assign alu_binv = w_active & w_op_eff[2];
    assign alu_opA  = w_active & w_op_eff[1];
    assign alu_opB  = w_active & w_op_eff[0];
    assign alu_less = (r_state == PASS2) && (r_idx == '0) && (r_op == OP_SLT) ? r_set : 1'b0;

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_ovf;
    assign err      = r_err;
    assign zero     = (r_result == '0);

    // Sequencer FSM: latch on start, run the passes bit by bit, pulse done for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_set    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= opcode;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_set    <= 1'b0;
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_err    <= ~w_supported;
                        if (!w_supported) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= (opcode == OP_SLT) ? PASS1 : PASS2;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                PASS1: begin
                    r_carry <= alu_cout;
                    if (r_idx == LAST) begin
                        // sum MSB corrected by MSB overflow gives the true sign of a-b
                        r_set   <= alu_result ^ (w_cin ^ alu_cout);
                        r_idx   <= '0;
                        r_state <= PASS2;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                PASS2: begin
                    r_carry         <= alu_cout;
                    r_result[r_idx] <= alu_result;
                    if (r_idx == LAST) begin
                        if ((r_op == OP_ADD) || (r_op == OP_SUB))
                            r_ovf <= w_cin ^ alu_cout;
                        r_idx   <= '0;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for the bit-serial ALU sequencer with a behavioural 1-bit slice.
// Latency: checks done timing against the word-level reference per operation.
// Backpressure: injects a start while busy and expects it to be dropped.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, zero, overflow, err;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_less, alu_cin, alu_ainv, alu_binv, alu_opA, alu_opB;
    logic         alu_result, alu_cout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         err;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb[$];

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow), .err(err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_less(alu_less), .alu_cin(alu_cin),
        .alu_ainv(alu_ainv), .alu_binv(alu_binv), .alu_opA(alu_opA), .alu_opB(alu_opB),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural slice: op 00 AND, 01 OR, 10 XOR (or LESS when binv), 11 full-adder sum
    logic s_ae, s_be;
    always_comb begin
        s_ae       = alu_a ^ alu_ainv;
        s_be       = alu_b ^ alu_binv;
        alu_cout   = (s_ae & s_be) | (alu_cin & (s_ae ^ s_be));
        alu_result = 1'b0;
        case ({alu_opA, alu_opB})
            2'b00:   alu_result = s_ae & s_be;
            2'b01:   alu_result = s_ae | s_be;
            2'b10:   alu_result = alu_binv ? alu_less : (s_ae ^ s_be);
            default: alu_result = s_ae ^ s_be ^ alu_cin;
        endcase
    end

    function automatic logic [7:0] drive_vec();
        return {alu_a, alu_b, alu_less, alu_cin, alu_ainv, alu_binv, alu_opA, alu_opB};
    endfunction

    // Word-level reference for result, flags and latency
    function automatic exp_t ref_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W-1:0] r;
        r     = '0;
        e.ovf = 1'b0;
        e.err = 1'b0;
        e.lat = 8'(W + 1);
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x ^ y;
            4'b0011: begin
                r     = x + y;
                e.ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'b0111: begin
                r     = x - y;
                e.ovf = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'b0110: begin
                r     = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
                e.lat = 8'(2 * W + 1);
            end
            4'b1100: r = ~(x | y);
            default: begin
                e.err = 1'b1;
                e.lat = 8'd1;
            end
        endcase
        e.res  = r;
        e.zero = (r == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation, wait for done (bounded), compare against the scoreboard head
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int inject_at, output logic cin0);
        exp_t e;
        int   n;
        logic seen;
        @(negedge clk);
        opcode = op; a = x; b = y; start = 1'b1;
        sb.push_back(ref_op(op, x, y));
        @(posedge clk);
        #1;
        start = 1'b0; a = ~x; b = ~y;
        n = 1; seen = 1'b0; cin0 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n == 1) cin0 = alu_cin;
            if (n == inject_at) begin
                start = 1'b1; opcode = 4'b0011; a = '0; b = '0;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        e = sb.pop_front();
        chk({tag, "_result"},   64'(result),   64'(e.res));
        chk({tag, "_zero"},     64'(zero),     64'(e.zero));
        chk({tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
        chk({tag, "_err"},      64'(err),      64'(e.err));
        chk({tag, "_latency"},  64'(n),        64'(e.lat));
        chk({tag, "_drive_at_done"}, 64'({busy, drive_vec()}), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"},  64'(done),   64'd0);
        chk({tag, "_result_hold"}, 64'(result), 64'(e.res));
    endtask

    logic cin0;

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
        #1;
        chk("rst_busy",     64'(busy),        64'd0);
        chk("rst_done",     64'(done),        64'd0);
        chk("rst_result",   64'(result),      64'd0);
        chk("rst_zero",     64'(zero),        64'd1);
        chk("rst_flags",    64'({overflow, err}), 64'd0);
        chk("rst_drive",    64'(drive_vec()), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_op("add_ovf", 4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 0, cin0);
        run_op("sub_eq",  4'b0111, 32'h0000_0005, 32'h0000_0005, 0, cin0);
        chk("sub_cin_bit0", 64'(cin0), 64'd1);
        run_op("slt_neg", 4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 0, cin0);
        run_op("slt_ovf", 4'b0110, 32'h8000_0000, 32'h7FFF_FFFF, 0, cin0);
        run_op("slt_gt",  4'b0110, 32'h0000_0010, 32'hFFFF_FFF0, 0, cin0);
        run_op("nor_inj", 4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 10, cin0);
        run_op("bad_op",  4'b0101, 32'h1234_5678, 32'h9ABC_DEF0, 0, cin0);
        run_op("and",     4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0, cin0);
        run_op("or",      4'b0001, 32'hA000_0005, 32'h0500_0050, 0, cin0);
        run_op("xor",     4'b0010, 32'hDEAD_BEEF, 32'hFFFF_0000, 0, cin0);

        // Reset mid-PASS2 of an ADD at bit 15
        @(negedge clk);
        opcode = 4'b0011; a = 32'h1234_5678; b = 32'h0000_0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy",   64'(busy),        64'd0);
        chk("mid_rst_result", 64'(result),      64'd0);
        chk("mid_rst_zero",   64'(zero),        64'd1);
        chk("mid_rst_flags",  64'({done, overflow, err}), 64'd0);
        chk("mid_rst_drive",  64'(drive_vec()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("add_after_rst", 4'b0011, 32'h0000_0003, 32'h0000_0004, 0, cin0);

        for (int i = 0; i < 6; i++) begin
            logic [3:0] ops [7];
            ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b1100};
            run_op("rnd", ops[$urandom_range(0, 6)], W'($urandom), W'($urandom), 0, cin0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width in bits; legal values are 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning the asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, meaning a request to begin an operation.
REQ-005 The block SHALL have port opcode, input, 4 bits, meaning {ainv,binv,opA,opB}: AND 0000, OR 0001, XOR 0010, ADD 0011, SUB 0111, SLT 0110, NOR 1100.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each, meaning the operands.
REQ-007 The block SHALL have port busy, output, 1 bit, meaning an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse marking the result as valid.
REQ-009 The block SHALL have port result, output, WIDTH bits, meaning the operation result.
REQ-010 The block SHALL have ports zero, overflow and err, output, 1 bit each, meaning result==0, signed overflow and unsupported opcode.
REQ-011 The block SHALL have slice drive ports alu_a, alu_b, alu_less, alu_cin, alu_ainv, alu_binv, alu_opA and alu_opB, output, 1 bit each, meaning the inputs of one external 1-bit ALU slice.
REQ-012 The block SHALL have slice return ports alu_result and alu_cout, input, 1 bit each, meaning the combinational outputs of the slice.

Function
REQ-013 The block SHALL be a bit-serial sequencer that processes one bit per cycle, LSB first, through the external slice.
- REQ-014 The block SHALL have FSM states IDLE, PASS1, PASS2 and DONE.
- REQ-015 The block SHALL accept start only in IDLE; start in any other state is ignored, with no effect on operands or counters.
- REQ-016 On an accepted start the block SHALL latch a, b and opcode, clear bit_idx and the carry register, and clear err.
- REQ-017 On an accepted start the block SHALL go to PASS1 for SLT, to PASS2 for the other six supported opcodes, and to DONE with err=1 and result=0 for any unsupported opcode.
- REQ-018 Slice drive ports SHALL be combinational from registered state:
  - alu_a = a_l[bit_idx], alu_b = b_l[bit_idx];
  - alu_ainv, alu_binv, alu_opA, alu_opB = latched opcode bits, except that PASS1 drives 0111;
  - alu_cin = binv_eff when bit_idx==0, else the carry register;
  - all drive ports SHALL be 0 in IDLE and DONE.
- REQ-019 In PASS1 and PASS2 the block SHALL load the carry register with alu_cout on every cycle.
- REQ-020 In PASS2 the block SHALL write alu_result into result[bit_idx] each cycle.
- REQ-021 In PASS1 the block SHALL NOT modify result.
- REQ-022 In PASS1, at bit_idx==WIDTH-1, the block SHALL store set = alu_result XOR (alu_cin XOR alu_cout), i.e. the true sign of a-b.
- REQ-023 alu_less SHALL equal set in PASS2 when bit_idx==0 and the opcode is SLT, and SHALL be 0 otherwise.
- REQ-024 bit_idx SHALL increment each PASS cycle; at WIDTH-1 it wraps to 0 and the FSM moves PASS1->PASS2 or PASS2->DONE.
- REQ-025 For ADD and SUB, overflow SHALL be captured as alu_cin XOR alu_cout at MSB in PASS2; for all other opcodes overflow SHALL be 0.
- REQ-026 busy SHALL be 1 in PASS1 and PASS2 and 0 elsewhere.
- REQ-027 done SHALL be 1 only in DONE, which lasts exactly one cycle and then returns to IDLE.
- REQ-028 zero SHALL equal (result==0) and SHALL be valid while done==1.
- REQ-029 result, overflow, zero and err SHALL hold their values after DONE until the next accepted start.
- REQ-030 Latency, counted from the edge accepting start: done is high in the cycle after edge WIDTH+1 for non-SLT opcodes, edge 2*WIDTH+1 for SLT, and edge 1 for unsupported opcodes.

Reset
REQ-031 Reset assertion SHALL take effect immediately, in any state including mid-PASS, and force the following:
- state IDLE;
- bit_idx, carry and set cleared to 0;
- result 0;
- busy, done, overflow and err all 0;
- zero 1;
- all slice drive ports 0.
REQ-032 The first start after reset deassertion SHALL be accepted normally, and no partial result from the aborted operation SHALL be visible.

Verification (WIDTH=32, bench models the slice with the 7-function behaviour)
REQ-033 ADD, a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, overflow=1, zero=0, done 33 cycles after start.
REQ-034 SUB, a=b=0x00000005 -> result 0x00000000, zero=1, overflow=0; alu_cin=1 observed at bit 0.
REQ-035 SLT, a=0xFFFFFFFF (-1), b=0x00000001 -> result 0x00000001, done after 65 cycles; SLT with a=0x80000000, b=0x7FFFFFFF -> result 0x00000001 (sign taken from overflow-corrected set).
REQ-036 NOR, a=0x0F0F0F0F, b=0x00FF00FF -> result 0xF000F000; start pulsed again at cycle 10 -> ignored, result unchanged.
REQ-037 Unsupported opcode 0101 -> err=1, result=0, done one cycle after start, slice drive ports remain 0.
REQ-038 Reset asserted mid-PASS2 of an ADD at bit 15 -> immediately IDLE, busy=0, result=0; a subsequent ADD 3+4 -> result 0x00000007.
